// File: rtl/video_filter_ctrl.sv
// Frame sequencer routing AXI4-Stream video through the greyscale filter or a 1-cycle bypass register.
// Latency 1 on both paths; filter held to one beat in flight; define VFC_FRAME_STATS_EN for frame/drop counters.
module video_filter_ctrl #(
  parameter int DATA_W = 24,
  parameter int DIM_W  = 12
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cfg_filter_en,
  input  logic [DIM_W-1:0]  cfg_active_cols,
  input  logic [DIM_W-1:0]  cfg_active_lines,
  input  logic [DATA_W-1:0] s_axis_video_tdata,
  input  logic              s_axis_video_tvalid,
  input  logic              s_axis_video_tlast,
  input  logic              s_axis_video_tuser,
  output logic              s_axis_video_tready,
  output logic [DATA_W-1:0] flt_tdata,
  output logic              flt_tvalid,
  output logic              flt_tlast,
  output logic              flt_tuser,
  input  logic              flt_tready,
  input  logic [DATA_W-1:0] flt_res_tdata,
  input  logic              flt_res_tvalid,
  input  logic              flt_res_tlast,
  input  logic              flt_res_tuser,
  output logic              flt_res_tready,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  output logic              m_axis_video_tlast,
  output logic              m_axis_video_tuser,
  input  logic              m_axis_video_tready,
  output logic              mode_active,
  output logic              busy,
  output logic              sts_err_eol_early,
  output logic              sts_err_eol_late,
  output logic              sts_err_sof_early,
  input  logic              sts_clr,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_live;
  logic              r_mode;
  logic              r_outstanding;
  logic [DIM_W-1:0]  r_col;
  logic [DIM_W-1:0]  r_line;
  logic              r_byp_vld;
  logic [DATA_W-1:0] r_byp_dat;
  logic              r_byp_last;
  logic              r_byp_user;
  logic              r_err_early;
  logic              r_err_late;
  logic              r_err_sof;

  logic [DIM_W-1:0]  w_cols_m1;
  logic [DIM_W-1:0]  w_lines_m1;
  logic [DIM_W-1:0]  w_col_cur;
  logic [DIM_W-1:0]  w_line_cur;
  logic [DIM_W-1:0]  w_col_nxt;
  logic [DIM_W-1:0]  w_line_nxt;
  logic              w_mode_eff;
  logic              w_res_hs;
  logic              w_flt_ok;
  logic              w_byp_take;
  logic              w_byp_ok;
  logic              w_route_ok;
  logic              w_s_rdy;
  logic              w_route;
  logic              w_fwd;
  logic              w_byp_load;
  logic              w_drop;
  logic              w_frame_done;
  logic              w_set_early;
  logic              w_set_late;
  logic              w_set_sof;

  // Zero-sized geometry is illegal and behaves as a size of one.
  assign w_cols_m1  = (cfg_active_cols  == '0) ? '0 : cfg_active_cols  - DIM_W'(1);
  assign w_lines_m1 = (cfg_active_lines == '0) ? '0 : cfg_active_lines - DIM_W'(1);

  // The SOF beat is routed in the IDLE cycle, before r_mode has been latched.
  assign w_mode_eff = (r_state == ST_IDLE) ? cfg_filter_en : r_mode;
  assign w_col_cur  = (r_state == ST_IDLE) ? '0 : r_col;
  assign w_line_cur = (r_state == ST_IDLE) ? '0 : r_line;

  assign flt_res_tready = r_mode & m_axis_video_tready;
  assign w_res_hs       = flt_res_tvalid & flt_res_tready;
  assign w_flt_ok       = flt_tready & (~r_outstanding | w_res_hs);
  assign w_byp_take     = r_byp_vld & ~r_mode & m_axis_video_tready;
  assign w_byp_ok       = ~r_byp_vld | w_byp_take;
  assign w_route_ok     = w_mode_eff ? w_flt_ok : w_byp_ok;

  always_comb begin
    w_state_nxt  = r_state;
    w_s_rdy      = 1'b0;
    w_route      = 1'b0;
    w_drop       = 1'b0;
    w_frame_done = 1'b0;
    w_col_nxt    = r_col;
    w_line_nxt   = r_line;
    w_set_early  = 1'b0;
    w_set_late   = 1'b0;
    w_set_sof    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_rdy = s_axis_video_tuser ? (r_live & w_route_ok) : r_live;
        if (s_axis_video_tvalid && w_s_rdy) begin
          if (s_axis_video_tuser) begin
            w_route = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // A premature SOF is left on the bus and picked up again from IDLE.
        if (s_axis_video_tvalid && s_axis_video_tuser) begin
          w_set_sof   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_s_rdy = w_route_ok;
          w_route = s_axis_video_tvalid & w_route_ok;
        end
      end
      ST_DRAIN: begin
        if (!r_outstanding && !r_byp_vld) begin
          w_state_nxt  = ST_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_route) begin
      w_state_nxt = ST_RUN;
      w_line_nxt  = w_line_cur;
      if (s_axis_video_tlast) begin
        w_set_early = (w_col_cur < w_cols_m1);
        w_col_nxt   = '0;
        if (w_line_cur == w_lines_m1) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_line_nxt = w_line_cur + DIM_W'(1);
        end
      end else begin
        w_set_late = (w_col_cur == w_cols_m1);
        w_col_nxt  = (&w_col_cur) ? w_col_cur : w_col_cur + DIM_W'(1);
      end
    end
  end

  assign w_fwd      = w_route & w_mode_eff;
  assign w_byp_load = w_route & ~w_mode_eff;

  assign s_axis_video_tready = w_s_rdy;
  assign flt_tvalid          = w_fwd;
  assign flt_tdata           = w_fwd ? s_axis_video_tdata : '0;
  assign flt_tlast           = w_fwd & s_axis_video_tlast;
  assign flt_tuser           = w_fwd & s_axis_video_tuser;

  assign m_axis_video_tvalid = r_mode ? flt_res_tvalid : r_byp_vld;
  assign m_axis_video_tdata  = r_mode ? flt_res_tdata  : r_byp_dat;
  assign m_axis_video_tlast  = r_mode ? flt_res_tlast  : r_byp_last;
  assign m_axis_video_tuser  = r_mode ? flt_res_tuser  : r_byp_user;

  assign mode_active       = r_mode;
  assign busy              = (r_state != ST_IDLE);
  assign sts_err_eol_early = r_err_early;
  assign sts_err_eol_late  = r_err_late;
  assign sts_err_sof_early = r_err_sof;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_mode  <= 1'b0;
      r_col   <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      r_col   <= w_col_nxt;
      r_line  <= w_line_nxt;
      if (r_state == ST_IDLE && w_route) begin
        r_mode <= cfg_filter_en;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_outstanding <= 1'b0;
    end else begin
      case ({w_fwd, w_res_hs})
        2'b10:   r_outstanding <= 1'b1;
        2'b01:   r_outstanding <= 1'b0;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_byp_vld  <= 1'b0;
      r_byp_dat  <= '0;
      r_byp_last <= 1'b0;
      r_byp_user <= 1'b0;
    end else if (w_byp_load) begin
      r_byp_vld  <= 1'b1;
      r_byp_dat  <= s_axis_video_tdata;
      r_byp_last <= s_axis_video_tlast;
      r_byp_user <= s_axis_video_tuser;
    end else if (w_byp_take) begin
      r_byp_vld <= 1'b0;
    end
  end

  // A new error outranks a clear arriving in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
      r_err_sof   <= 1'b0;
    end else begin
      if (w_set_early) begin
        r_err_early <= 1'b1;
      end else if (sts_clr) begin
        r_err_early <= 1'b0;
      end
      if (w_set_late) begin
        r_err_late <= 1'b1;
      end else if (sts_clr) begin
        r_err_late <= 1'b0;
      end
      if (w_set_sof) begin
        r_err_sof <= 1'b1;
      end else if (sts_clr) begin
        r_err_sof <= 1'b0;
      end
    end
  end

`ifdef VFC_FRAME_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (sts_clr) begin
        r_frame_cnt <= {15'd0, w_frame_done};
        r_drop_cnt  <= {15'd0, w_drop};
      end else begin
        if (w_frame_done) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_drop ^ w_frame_done;
  assign frame_cnt      = '0;
  assign drop_cnt       = '0;
`endif

endmodule

// File: doc/video_filter_ctrl.md
Name: video_filter_ctrl

Overview:
- Frame-level sequencer in front of the greyscale filter stage.
- Receives the AXI4-Stream video from the video-in bridge and routes each frame either through the greyscale filter or through an equal-latency bypass register.
- Mode changes take effect only at start-of-frame (tuser), after the filter path has drained.
- Checks line/frame geometry and paces the filter so that it never holds more than one beat, because the filter does not honour output backpressure.

Parameters:
- DATA_W, 24, pixel width (RGB888).
- DIM_W, 12, width of the column/line configuration and counters.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_filter_en  in  1  1=greyscale path, 0=bypass; sampled at SOF only.
- cfg_active_cols  in  DIM_W  pixels per line; 0 is illegal and treated as 1.
- cfg_active_lines  in  DIM_W  lines per frame; 0 is illegal and treated as 1.
- s_axis_video_tdata/tvalid/tlast/tuser  in  DATA_W/1/1/1  upstream stream.
- s_axis_video_tready  out  1  upstream ready.
- flt_tdata/tvalid/tlast/tuser  out  DATA_W/1/1/1  beat to filter input.
- flt_tready  in  1  filter input ready.
- flt_res_tdata/tvalid/tlast/tuser  in  DATA_W/1/1/1  filter output.
- flt_res_tready  out  1  ready to filter output.
- m_axis_video_tdata/tvalid/tlast/tuser  out  DATA_W/1/1/1  downstream stream to the video-out bridge.
- m_axis_video_tready  in  1  downstream ready.
- mode_active  out  1  mode latched for the current frame.
- busy  out  1  state != IDLE.
- sts_err_eol_early, sts_err_eol_late, sts_err_sof_early  out  1 each  sticky error flags.
- sts_clr  in  1  pulse; clears sticky flags and counters.
- frame_cnt  out  16  completed frames (see Optional Feature).
- drop_cnt  out  16  beats discarded in IDLE (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE.
  - All tvalid outputs, s_axis_video_tready and flt_res_tready = 0.
  - Data/tlast/tuser outputs = 0; mode_active = 0.
  - Sticky flags and counters = 0; outstanding = 0; bypass buffer empty.
- Reset mid-frame discards all in-flight beats. No partial-beat recovery.
- States IDLE, RUN, DRAIN:
  - IDLE:
    - s_axis_video_tready = 1.
    - A beat with tuser=0 is accepted and discarded; drop_cnt increments.
    - A beat with tuser=1: latch mode_active = cfg_filter_en, col = line = 0, go to RUN. That beat is routed in the same cycle as a RUN beat.
  - RUN:
    - Route each accepted beat to the latched path.
    - col increments per beat.
    - On tlast: col = 0, line increments.
    - When tlast arrives with line == cfg_active_lines-1, the beat is routed and the state goes to DRAIN.
  - DRAIN:
    - s_axis_video_tready = 0.
    - Leave for IDLE when outstanding == 0 and the bypass buffer is empty.
    - frame_cnt increments on that transition.
- Geometry checks in RUN:
  - tlast with col < cols-1: set sts_err_eol_early; line still advances.
  - Beat at col == cols-1 without tlast: set sts_err_eol_late. Counting continues until tlast, with col saturating at all ones.
  - tuser=1 on a non-first beat: set sts_err_sof_early. The beat is NOT accepted (s_axis_video_tready = 0 that cycle), state goes to DRAIN, and the beat is taken as SOF from IDLE after the drain.
- Filter path:
  - outstanding is 0 or 1.
  - Forward when flt_tready = 1 and (outstanding == 0, or outstanding == 1 and the filter result is accepted downstream this cycle).
  - flt_tvalid = s_axis_video_tvalid under that condition. The upstream beat is accepted on the same condition.
  - flt_res_tready = m_axis_video_tready when mode_active = 1.
  - outstanding +1 on forward, -1 on result handshake; both in the same cycle leave it unchanged.
- Bypass path:
  - One-entry register, 1-cycle latency matching the filter.
  - Load when empty, or when its beat is taken downstream the same cycle.
- Output mux:
  - Selected by mode_active: filter result, or the bypass buffer.
  - m_axis_video_* is a direct mux of registered sources; no combinational path from s_axis_video_tvalid.
- Latency and throughput:
  - Input-to-output latency is 1 cycle on both paths.
  - Full throughput of 1 beat/cycle while m_axis_video_tready = 1.
- Simultaneous events:
  - sts_clr together with an error event: the error wins (flag ends at 1).
  - sts_clr together with a frame completion: frame_cnt = 1.
- A cfg_filter_en change mid-frame has no effect until the next SOF.

Optional Feature:
- Macro VFC_FRAME_STATS_EN.
- Defined: frame_cnt and drop_cnt are live 16-bit wrapping counters, cleared by sts_clr.
- Undefined: both ports are tied to 0, the counter logic is omitted, and sts_clr clears only the flags.

Test Plan:
- Setup for all scenarios: cols=4, lines=2, cfg_filter_en=1, sink always ready.
  - Stimulus: SOF frame of 8 beats, all pixels 0xFF0000.
  - Required: 8 output beats of 0x4B4B4B, tlast on beats 4 and 8, tuser on beat 1, latency 1, frame_cnt=1, no errors.
- Mode switch:
  - Stimulus: set cfg_filter_en=0 during frame 1 beat 3; send frames 1 and 2.
  - Required: frame 1 fully greyscale; frame 2 bypassed unchanged (0x123456 out as 0x123456); mode_active changes only after DRAIN.
- Backpressure:
  - Stimulus: m_axis_video_tready toggled 1,0,0,1 repeatedly through a filter frame.
  - Required: outstanding never exceeds 1, no beat lost or duplicated, output order preserved.
- Geometry errors:
  - Early tlast at col 1: sts_err_eol_early=1.
  - A missing tlast at col 3: sts_err_eol_late=1.
  - Then sts_clr: both flags return to 0.
- SOF and drop handling:
  - Stimulus: tuser=1 on frame beat 5.
  - Required: sts_err_sof_early=1, tready low through DRAIN, that beat starts a new frame, frame_cnt +1.
  - Stimulus: 3 beats with tuser=0 while in IDLE.
  - Required: drop_cnt=3.
- Reset:
  - Stimulus: aresetn asserted mid-frame while m_axis_video_tvalid=1.
  - Required: all outputs 0 immediately (asynchronous); after release, state is IDLE and the next SOF frame completes correctly.
